sync0_supervisor: RTL and testbench

- Qualifies the SYNC0 edge stream before it reaches the synchronizer and the modulation/sequence sync masters.
- Measures the SYNC0 period in sys_clk cycles and runs a lock state machine (IDLE/ACQUIRE/LOCKED/HOLDOVER).
- Emits a qualified sync pulse, realignment (resync) requests, lock status and a glitch/error counter readable via config_manager.

---
 rtl/sync0_supervisor.sv | 191 +++++++++++++++++++
 tb/tb_sync0_supervisor.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync0_supervisor.sv
// sync0_supervisor: qualifies SYNC0 edges by period and runs the IDLE/ACQUIRE/LOCKED/HOLDOVER lock machine.
// Latency: sync_valid/resync/lost are registered, one cycle after the causing edge or window close.
// Backpressure: none; every edge is judged in the cycle it arrives and is never stalled.
module sync0_supervisor #(
  parameter int SYS_CLK_FREQ = 20480000,
  parameter int SYNC0_FREQ   = 2000,
  parameter int TOL          = 8,
  parameter int LOCK_COUNT   = 4,
  parameter int HOLDOVER_MAX = 16
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       sync_edge,
  input  logic       clr_err,
  output logic       sync_valid,
  output logic       resync,
  output logic       lost,
  output logic [1:0] state,
  output logic       locked,
  output logic [7:0] err_cnt
);

  localparam int NOMINAL = SYS_CLK_FREQ / SYNC0_FREQ;
  localparam int GW      = $clog2(LOCK_COUNT + 1);
  localparam int MW      = $clog2(HOLDOVER_MAX + 1);

  // Acceptance window on the measured period P = cnt + 1.
  localparam logic [16:0] P_MIN     = 17'(NOMINAL - TOL);
  localparam logic [16:0] P_MAX     = 17'(NOMINAL + TOL);
  // Last count at which an edge can still land in the window.
  localparam logic [15:0] CLOSE_CNT = 16'(NOMINAL + TOL - 1);
  // Reloading TOL at window close keeps phase as if an edge had arrived at NOMINAL.
  localparam logic [15:0] TOL_CNT   = 16'(TOL);
  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_COUNT - 1);
  localparam logic [MW-1:0] MISS_LAST = MW'(HOLDOVER_MAX - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2,
    HOLDOVER = 2'd3
  } state_t;

  state_t        cur_state;
  state_t        nxt_state;
  logic [15:0]   cnt;
  logic [15:0]   cnt_nxt;
  logic [15:0]   cnt_inc;
  logic [16:0]   period;
  logic          in_window;
  logic          early;
  logic          window_close;
  logic [GW-1:0] good;
  logic [GW-1:0] good_nxt;
  logic [MW-1:0] miss;
  logic [MW-1:0] miss_nxt;
  logic          err_inc;
  logic          sync_valid_nxt;
  logic          resync_nxt;
  logic          lost_nxt;

  // Period measurement and window classification of the current cycle.
  always_comb begin
    cnt_inc      = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    period       = {1'b0, cnt} + 17'd1;
    in_window    = (period >= P_MIN) && (period <= P_MAX);
    early        = (period < P_MIN);
    window_close = (cnt == CLOSE_CNT) && !sync_edge;
  end

  // Next-state, counter updates and pulse requests.
  always_comb begin
    nxt_state      = cur_state;
    cnt_nxt        = cnt_inc;
    good_nxt       = good;
    miss_nxt       = miss;
    err_inc        = 1'b0;
    sync_valid_nxt = 1'b0;
    resync_nxt     = 1'b0;
    lost_nxt       = 1'b0;

    if (!enable) begin
      nxt_state = IDLE;
      cnt_nxt   = '0;
      good_nxt  = '0;
      miss_nxt  = '0;
    end else begin
      case (cur_state)
        IDLE: begin
          cnt_nxt = '0;
          if (sync_edge) begin
            nxt_state  = ACQUIRE;
            good_nxt   = '0;
            resync_nxt = 1'b1;
          end
        end
        ACQUIRE: begin
          if (sync_edge) begin
            cnt_nxt = '0;
            if (in_window) begin
              if (good == GOOD_LAST) begin
                nxt_state      = LOCKED;
                good_nxt       = '0;
                sync_valid_nxt = 1'b1;
              end else begin
                good_nxt = good + GW'(1);
              end
            end else begin
              good_nxt   = '0;
              resync_nxt = 1'b1;
              err_inc    = 1'b1;
            end
          end
        end
        LOCKED: begin
          if (sync_edge && in_window) begin
            cnt_nxt        = '0;
            sync_valid_nxt = 1'b1;
          end else if (sync_edge && early) begin
            err_inc = 1'b1;
          end else if (window_close) begin
            nxt_state = HOLDOVER;
            cnt_nxt   = TOL_CNT;
            miss_nxt  = MW'(1);
          end
        end
        HOLDOVER: begin
          if (sync_edge && in_window) begin
            nxt_state      = LOCKED;
            cnt_nxt        = '0;
            miss_nxt       = '0;
            sync_valid_nxt = 1'b1;
          end else if (sync_edge && early) begin
            err_inc = 1'b1;
          end else if (window_close) begin
            cnt_nxt = TOL_CNT;
            if (miss == MISS_LAST) begin
              nxt_state = ACQUIRE;
              good_nxt  = '0;
              miss_nxt  = '0;
              lost_nxt  = 1'b1;
            end else begin
              miss_nxt = miss + MW'(1);
            end
          end
        end
        default: begin
          nxt_state = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // State, counters and registered pulse outputs.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      cur_state  <= IDLE;
      cnt        <= '0;
      good       <= '0;
      miss       <= '0;
      sync_valid <= 1'b0;
      resync     <= 1'b0;
      lost       <= 1'b0;
    end else begin
      cur_state  <= nxt_state;
      cnt        <= cnt_nxt;
      good       <= good_nxt;
      miss       <= miss_nxt;
      sync_valid <= sync_valid_nxt;
      resync     <= resync_nxt;
      lost       <= lost_nxt;
    end
  end

  // Saturating rejected-edge counter; a clear in the same cycle as an increment wins.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      err_cnt <= '0;
    end else if (clr_err) begin
      err_cnt <= '0;
    end else if (err_inc && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

  assign state  = cur_state;
  assign locked = (cur_state == LOCKED);

endmodule

// File: tb/tb_sync0_supervisor.sv
// tb_sync0_supervisor: checks sync0_supervisor with a scaled nominal period (1024 cycles, window 1016..1032).
// Latency: expected pulses are queued one cycle after the driving cycle and matched by a monitor.
// Backpressure: not applicable; stimulus is a cycle-by-cycle edge stream.
module tb_sync0_supervisor;

  localparam logic [2:0] P_SV = 3'b001;
  localparam logic [2:0] P_RS = 3'b010;
  localparam logic [2:0] P_LS = 3'b100;

  logic       sys_clk;
  logic       reset;
  logic       enable;
  logic       sync_edge;
  logic       clr_err;
  logic       sync_valid;
  logic       resync;
  logic       lost;
  logic [1:0] state;
  logic       locked;
  logic [7:0] err_cnt;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    int         cyc;
    logic [2:0] pulses;
  } exp_t;

  exp_t exp_q[$];

  typedef struct {
    int         gap;
    logic       exp_sv;
    logic [1:0] exp_state;
    int         exp_err;
  } vec_t;

  vec_t vecs[9];

  sync0_supervisor #(
    .SYS_CLK_FREQ(2048000),
    .SYNC0_FREQ  (2000),
    .TOL         (8),
    .LOCK_COUNT  (4),
    .HOLDOVER_MAX(16)
  ) dut (
    .sys_clk   (sys_clk),
    .reset     (reset),
    .enable    (enable),
    .sync_edge (sync_edge),
    .clr_err   (clr_err),
    .sync_valid(sync_valid),
    .resync    (resync),
    .lost      (lost),
    .state     (state),
    .locked    (locked),
    .err_cnt   (err_cnt)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Pulse scoreboard: every pulse must match the queued expectation for that cycle.
  always @(negedge sys_clk) begin
    logic [2:0] seen;
    exp_t       front;
    seen = {lost, resync, sync_valid};
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      front = exp_q.pop_front();
      tests++;
      fails++;
      $display("FAIL pulse_missing cyc=%0d expected pulses=%b never seen", front.cyc, front.pulses);
    end
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      front = exp_q.pop_front();
      tests++;
      if (seen != front.pulses) begin
        fails++;
        $display("FAIL pulse_match cyc=%0d got {lost,resync,sv}=%b expected %b", cyc, seen, front.pulses);
      end
    end else if (seen != 3'b000) begin
      tests++;
      fails++;
      $display("FAIL pulse_unexpected cyc=%0d got {lost,resync,sv}=%b expected 000", cyc, seen);
    end
  end

  task automatic step(input logic e);
    sync_edge = e;
    @(posedge sys_clk);
    #1;
    sync_edge = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0);
  endtask

  task automatic expect_pulse(input logic [2:0] p);
    exp_t item;
    item.cyc    = cyc + 1;
    item.pulses = p;
    exp_q.push_back(item);
  endtask

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  // Edge after p cycles from the previous edge, optionally expecting a pulse.
  task automatic period_edge(input int p, input logic [2:0] exp_p);
    idle(p - 1);
    if (exp_p != 3'b000) expect_pulse(exp_p);
    step(1'b1);
  endtask

  task automatic acquire_lock(input string tag);
    expect_pulse(P_RS);
    step(1'b1);
    check({tag, "_acq_state"}, int'(state), 1);
    for (int i = 0; i < 3; i++) begin
      period_edge(1024, 3'b000);
      check($sformatf("%s_acq%0d_state", tag, i), int'(state), 1);
    end
    period_edge(1024, P_SV);
    check({tag, "_lock_state"}, int'(state), 2);
    check({tag, "_lock_locked"}, int'(locked), 1);
  endtask

  initial begin
    vecs[0] = '{1024, 1'b1, 2'd2, 0};
    vecs[1] = '{1016, 1'b1, 2'd2, 0};
    vecs[2] = '{1032, 1'b1, 2'd2, 0};
    vecs[3] = '{1015, 1'b0, 2'd2, 1};
    vecs[4] = '{9,    1'b1, 2'd2, 1};
    vecs[5] = '{1033, 1'b0, 2'd3, 2};
    vecs[6] = '{1015, 1'b1, 2'd2, 2};
    vecs[7] = '{500,  1'b0, 2'd2, 3};
    vecs[8] = '{524,  1'b1, 2'd2, 3};

    reset     = 1'b1;
    enable    = 1'b0;
    sync_edge = 1'b0;
    clr_err   = 1'b0;
    idle(3);
    check("rst_state", int'(state), 0);
    check("rst_locked", int'(locked), 0);
    check("rst_err", int'(err_cnt), 0);
    check("rst_pulses", int'({lost, resync, sync_valid}), 0);
    reset = 1'b0;
    idle(2);

    // Edge while disabled is ignored.
    step(1'b1);
    check("dis_edge_state", int'(state), 0);
    enable = 1'b1;
    idle(5);

    acquire_lock("first");

    for (int i = 0; i < 9; i++) begin
      idle(vecs[i].gap - 1);
      if (vecs[i].exp_sv) expect_pulse(P_SV);
      step(1'b1);
      check($sformatf("vec%0d_state", i), int'(state), int'(vecs[i].exp_state));
      check($sformatf("vec%0d_err", i), int'(err_cnt), vecs[i].exp_err);
      check($sformatf("vec%0d_sv", i), int'(sync_valid), int'(vecs[i].exp_sv));
      check($sformatf("vec%0d_locked", i), int'(locked), (vecs[i].exp_state == 2'd2) ? 1 : 0);
    end

    // One dropped edge: holdover at +1032, relock on the edge at +2048.
    idle(1031);
    check("drop_pre_close", int'(state), 2);
    step(1'b0);
    check("drop_holdover", int'(state), 3);
    idle(1015);
    expect_pulse(P_SV);
    step(1'b1);
    check("drop_relock", int'(state), 2);

    // SYNC0 removed: the 16th window close is at +1032+15*1024.
    idle(16391);
    check("loss_pre_state", int'(state), 3);
    expect_pulse(P_LS);
    step(1'b0);
    check("loss_state", int'(state), 1);
    check("loss_locked", int'(locked), 0);
    idle(99);
    expect_pulse(P_RS);
    step(1'b1);
    check("resume_bad_err", int'(err_cnt), 4);
    for (int i = 0; i < 3; i++) begin
      period_edge(1024, 3'b000);
      check($sformatf("reacq%0d_state", i), int'(state), 1);
    end
    period_edge(1024, P_SV);
    check("reacq_lock", int'(state), 2);

    // Glitch burst saturates err_cnt without disturbing lock.
    for (int i = 0; i < 300; i++) begin
      step(1'b0);
      step(1'b1);
    end
    check("sat_err", int'(err_cnt), 255);
    check("sat_state", int'(state), 2);
    idle(423);
    expect_pulse(P_SV);
    step(1'b1);
    idle(99);
    step(1'b1);
    check("sat_hold", int'(err_cnt), 255);
    idle(99);
    clr_err = 1'b1;
    step(1'b1);
    clr_err = 1'b0;
    check("clr_wins", int'(err_cnt), 0);
    idle(823);
    expect_pulse(P_SV);
    step(1'b1);
    check("post_clr_state", int'(state), 2);
    idle(299);
    step(1'b1);
    check("post_clr_glitch", int'(err_cnt), 1);

    // enable dropped on an in-window edge: IDLE, no pulse, err holds.
    idle(723);
    enable = 1'b0;
    step(1'b1);
    check("dis_state", int'(state), 0);
    check("dis_locked", int'(locked), 0);
    check("dis_err", int'(err_cnt), 1);
    idle(3);
    enable = 1'b1;
    idle(3);
    acquire_lock("second");

    // Reset on an in-window edge: back to reset values, no pulse.
    idle(1023);
    reset = 1'b1;
    step(1'b1);
    check("mid_rst_state", int'(state), 0);
    check("mid_rst_err", int'(err_cnt), 0);
    check("mid_rst_locked", int'(locked), 0);
    reset = 1'b0;
    idle(4);

    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL queue_drain got %0d pending expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
